// File: rtl/peg_plotter.sv
// peg_plotter: turns one Mastermind peg draw request into a raster of VGA adapter pixel writes.
// Build option PEG_OUTLINE_EN draws the square's one-pixel border in black.
module peg_plotter #(
    parameter int unsigned BIG_SIZE   = 20,
    parameter int unsigned MED_SIZE   = 10,
    parameter int unsigned ORIGIN_X   = 40,
    parameter int unsigned ORIGIN_Y   = 10,
    parameter int unsigned SLOT_PITCH = 24,
    parameter int unsigned ROW_PITCH  = 22,
    parameter int unsigned ROWS       = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       shape,
    input  logic [1:0] slot,
    input  logic [3:0] row,
    input  logic [2:0] colour,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int unsigned X_W    = 9;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned CENTRE = (BIG_SIZE - MED_SIZE) / 2;

    localparam logic [OFS_W-1:0] BIG_LAST = OFS_W'(BIG_SIZE - 1);
    localparam logic [OFS_W-1:0] MED_LAST = OFS_W'(MED_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic               shape_q;
    logic [COL_W-1:0]   colour_q;
    logic [X_W-1:0]     base_x;
    logic [Y_W-1:0]     base_y;
    logic [OFS_W-1:0]   ox;
    logic [OFS_W-1:0]   oy;
    logic               bad;

    logic [OFS_W-1:0]   last;
    logic [COL_W-1:0]   px_colour;

    // Last offset along either axis for the latched shape.
    assign last = shape_q ? MED_LAST : BIG_LAST;

`ifdef PEG_OUTLINE_EN
    logic border;
    assign border    = (ox == '0) || (oy == '0) || (ox == last) || (oy == last);
    assign px_colour = border ? COL_W'(0) : colour_q;
`else
    assign px_colour = colour_q;
`endif

    // Sequencer: FIN is the cycle showing the last pixel; done is raised as it exits to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            ox         <= '0;
            oy         <= '0;
            shape_q    <= 1'b0;
            colour_q   <= '0;
            base_x     <= '0;
            base_y     <= '0;
            bad        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    busy     <= 1'b0;
                    vga_plot <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (32'(row) < ROWS) begin
                            shape_q  <= shape;
                            colour_q <= colour;
                            base_x   <= X_W'(ORIGIN_X + 32'(slot) * SLOT_PITCH
                                             + (shape ? CENTRE : 32'd0));
                            base_y   <= Y_W'(ORIGIN_Y + 32'(row) * ROW_PITCH
                                             + (shape ? CENTRE : 32'd0));
                            ox       <= '0;
                            oy       <= '0;
                            bad      <= 1'b0;
                            state    <= DRAW;
                        end else begin
                            // Out-of-range row: report immediately, nothing plotted.
                            bad   <= 1'b1;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= FIN;
                        end
                    end
                end

                DRAW: begin
                    vga_plot   <= 1'b1;
                    vga_x      <= base_x + X_W'(ox);
                    vga_y      <= base_y + Y_W'(oy);
                    vga_colour <= px_colour;
                    if (ox == last) begin
                        ox <= '0;
                        if (oy == last) begin
                            state <= FIN;
                        end else begin
                            oy <= oy + OFS_W'(1);
                        end
                    end else begin
                        ox <= ox + OFS_W'(1);
                    end
                end

                FIN: begin
                    vga_plot <= 1'b0;
                    done     <= ~bad;
                    busy     <= ~bad;
                    err      <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peg_plotter.sv
// Directed self-checking bench for peg_plotter: every plotted pixel is checked against
// a raster model, plus spot coordinates, done/err timing, busy, reset abort and busy-ignore.
module tb_peg_plotter;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       shape;
    logic [1:0] slot;
    logic [3:0] row;
    logic [2:0] colour;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    peg_plotter dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .shape      (shape),
        .slot       (slot),
        .row        (row),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #10 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int n_plot;
    int first_gap;
    int done_gap;
    int err_at_done;
    int got_done;
    int xs [400];
    int ys [400];
    int cs [400];

    logic       p_shape;
    logic [1:0] p_slot;
    logic [3:0] p_row;
    logic [2:0] p_colour;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected pixel colour for raster index i of a square of edge sz.
    function automatic int exp_col(input int i, input int sz, input int col);
`ifdef PEG_OUTLINE_EN
        int px = i % sz;
        int py = i / sz;
        if (px == 0 || py == 0 || px == sz - 1 || py == sz - 1) return 0;
`else
        if (sz < 0) return i;
`endif
        return col;
    endfunction

    // Runs from the accept edge until done (or stop_at plots); checks every pixel against the model.
    task automatic draw(input string tag, input int bx, input int by, input int sz,
                        input int col, input int poke_at, input int stop_at);
        int cyc = 0;
        int last_cyc = 0;
        int bad_px = 0;
        int bad_busy = 0;
        int budget = sz * sz + 10;
        n_plot = 0;
        first_gap = -1;
        done_gap = -1;
        err_at_done = -1;
        got_done = 0;
        while (cyc < budget && got_done == 0 && !(stop_at > 0 && n_plot >= stop_at)) begin
            step();
            cyc++;
            if (busy !== 1'b1) bad_busy++;
            if (vga_plot === 1'b1) begin
                if (first_gap < 0) begin
                    first_gap = cyc;
                    start = 1'b0;
                end
                if (n_plot < 400) begin
                    xs[n_plot] = int'(vga_x);
                    ys[n_plot] = int'(vga_y);
                    cs[n_plot] = int'(vga_colour);
                end
                if (int'(vga_x) != bx + n_plot % sz || int'(vga_y) != by + n_plot / sz
                    || int'(vga_colour) != exp_col(n_plot, sz, col))
                    bad_px++;
                n_plot++;
                last_cyc = cyc;
                if (n_plot == poke_at) begin
                    start  = 1'b1;
                    shape  = p_shape;
                    slot   = p_slot;
                    row    = p_row;
                    colour = p_colour;
                end
            end
            if (done === 1'b1) begin
                got_done = 1;
                done_gap = cyc - last_cyc;
                err_at_done = int'(err);
            end
        end
        chk({tag, "_pixels"}, bad_px, 0);
        chk({tag, "_busy"}, bad_busy, 0);
        if (stop_at == 0) chk({tag, "_done_seen"}, got_done, 1);
    endtask

    initial begin
        // 1: reset held with start high, then accept on first non-reset edge.
        reset = 1'b1; start = 1'b1; shape = 1'b0; slot = 2'd0; row = 4'd0; colour = 3'b100;
        p_shape = 1'b0; p_slot = 2'd0; p_row = 4'd0; p_colour = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outputs", int'({busy, done, err, vga_plot, vga_x, vga_y, vga_colour}), 0);
        end
        reset = 1'b0;

        // 2: big peg slot 0 row 0 colour 100.
        draw("big00", 40, 10, 20, 4, 0, 0);
        chk("big00_first_gap", first_gap, 2);
        chk("big00_count", n_plot, 400);
        chk("big00_p1_x", xs[0], 40);   chk("big00_p1_y", ys[0], 10);
        chk("big00_p20_x", xs[19], 59); chk("big00_p20_y", ys[19], 10);
        chk("big00_p21_x", xs[20], 40); chk("big00_p21_y", ys[20], 11);
        chk("big00_p400_x", xs[399], 59); chk("big00_p400_y", ys[399], 29);
        chk("big00_done_gap", done_gap, 1);
        chk("big00_err", err_at_done, 0);
        step();
        chk("big00_busy_after", int'(busy), 0);
        chk("big00_done_after", int'(done), 0);

        // 3: medium peg slot 3 row 9 colour 010.
        start = 1'b1; shape = 1'b1; slot = 2'd3; row = 4'd9; colour = 3'b010;
        draw("med39", 117, 213, 10, 2, 0, 0);
        chk("med39_count", n_plot, 100);
        chk("med39_p1_x", xs[0], 117);  chk("med39_p1_y", ys[0], 213);
        chk("med39_p10_x", xs[9], 126); chk("med39_p10_y", ys[9], 213);
        chk("med39_p100_x", xs[99], 126); chk("med39_p100_y", ys[99], 222);
        chk("med39_done_gap", done_gap, 1);
        step();

        // 4: new request pulsed during plot 50 is ignored; start then held for the next draw.
        start = 1'b1; shape = 1'b0; slot = 2'd1; row = 4'd2; colour = 3'b001;
        p_shape = 1'b1; p_slot = 2'd2; p_row = 4'd5; p_colour = 3'b110;
        draw("busy_ign", 64, 54, 20, 1, 50, 0);
        chk("busy_ign_count", n_plot, 400);
        chk("busy_ign_p400_x", xs[399], 83); chk("busy_ign_p400_y", ys[399], 73);
        chk("busy_ign_done_gap", done_gap, 1);
        draw("held", 93, 125, 10, 6, 0, 0);
        chk("held_first_gap", first_gap, 2);
        chk("held_count", n_plot, 100);
        chk("held_p100_x", xs[99], 102); chk("held_p100_y", ys[99], 134);
        step();
        chk("held_no_third", int'(busy), 0);

        // 5: row out of range.
        start = 1'b1; shape = 1'b0; slot = 2'd0; row = 4'd10; colour = 3'b111;
        step();
        start = 1'b0;
        chk("badrow_done", int'(done), 1);
        chk("badrow_err", int'(err), 1);
        chk("badrow_busy", int'(busy), 1);
        chk("badrow_plot", int'(vga_plot), 0);
        step();
        chk("badrow_done_clr", int'(done), 0);
        chk("badrow_err_clr", int'(err), 0);
        chk("badrow_idle", int'(busy), 0);

        // 6: reset during plot 150 aborts; next draw begins at offset (0,0).
        start = 1'b1; shape = 1'b0; slot = 2'd0; row = 4'd1; colour = 3'b101;
        draw("abort", 40, 32, 20, 5, 0, 150);
        chk("abort_reached", n_plot, 150);
        reset = 1'b1;
        step();
        chk("abort_plot", int'(vga_plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        start = 1'b1; shape = 1'b1; slot = 2'd0; row = 4'd0; colour = 3'b001;
        draw("after_abort", 45, 15, 10, 1, 0, 0);
        chk("after_abort_count", n_plot, 100);
        chk("after_abort_p1_x", xs[0], 45); chk("after_abort_p1_y", ys[0], 15);
        step();

        // 7: colour 111 big peg; border pixels black only with the outline build.
        start = 1'b1; shape = 1'b0; slot = 2'd0; row = 4'd0; colour = 3'b111;
        draw("outline", 40, 10, 20, 7, 0, 0);
        chk("outline_count", n_plot, 400);
`ifdef PEG_OUTLINE_EN
        chk("outline_c_40_10", cs[0], 0);
        chk("outline_c_50_10", cs[10], 0);
`else
        chk("outline_c_40_10", cs[0], 7);
        chk("outline_c_50_10", cs[10], 7);
`endif
        chk("outline_c_41_11", cs[21], 7);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
